// File: rtl/div_pkg.sv
// div_pkg: shared types, default width, derived-width helpers and the divide-by-zero quotient
package div_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int quot_w(input int n);
        return 2 * n;
    endfunction

    function automatic int part_w(input int n);
        return n + 1;
    endfunction

    // quotient reported for a zero divisor: all ones at the quotient width
    function automatic logic [63:0] dbz_quot(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
//   p     : current partial remainder (N+1 bits)
//   q_msb : dividend/quotient bit shifted into the partial remainder
//   d     : divisor
//   p_nxt : partial remainder after the trial subtraction
//   q_bit : resolved quotient bit (1 when the subtraction was kept)
module div_step
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   p,
    input  logic         q_msb,
    input  logic [N-1:0] d,
    output logic [N:0]   p_nxt,
    output logic         q_bit
);

    localparam int PW = part_w(N);

    logic [N+1:0] pp;
    logic [N+1:0] diff;

    // p never exceeds the divisor, so one extra guard bit keeps the shift lossless
    always_comb begin
        pp    = {p, q_msb};
        diff  = pp - {2'b00, d};
        q_bit = pp >= {2'b00, d};
        p_nxt = PW'(q_bit ? diff : pp);
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: iterative unsigned restoring divider, 2N-bit dividend / N-bit divisor
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (dividend, divisor)
//   out_valid/out_ready  : result handshake (quotient, remainder, div_by_zero)
//   Build option DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
//   reports its forced result the cycle after acceptance.
module seq_divider_16by8
    import div_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N-1:0]    dividend,
    input  logic [N-1:0]      divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    quotient,
    output logic [N-1:0]      remainder,
    output logic              div_by_zero
);

    localparam int QW = quot_w(N);
    localparam int PW = part_w(N);
    localparam logic [QW-1:0] Q_ONES = QW'(dbz_quot(QW));

    state_t        state, state_nxt;
    logic [PW-1:0] p, p_nxt;
    logic [QW-1:0] q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          dbz;
    logic          q_bit;
    logic          accept;
    logic          last;

    div_step #(.N(N)) u_step (
        .p     (p),
        .q_msb (q[QW-1]),
        .d     (d),
        .p_nxt (p_nxt),
        .q_bit (q_bit)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        accept    = in_valid && state == IDLE;
        last      = cnt == CW'(QW - 1);
        case (state)
`ifdef DIV_ZERO_FAST_EN
            IDLE:    state_nxt = accept ? ((divisor == '0) ? DONE : BUSY) : IDLE;
`else
            IDLE:    state_nxt = accept ? BUSY : IDLE;
`endif
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else if (accept) begin
            p   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= '0;
            dbz <= divisor == '0;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
                p <= {1'b0, dividend[N-1:0]};
                q <= Q_ONES;
            end
`endif
        end else if (state == BUSY) begin
            // a zero divisor leaves the low dividend bits in p naturally;
            // the quotient is forced explicitly on the final iteration
            p   <= p_nxt;
            q   <= (last && dbz) ? Q_ONES : {q[QW-2:0], q_bit};
            cnt <= cnt + 1'b1;
        end
    end

    assign quotient    = q;
    assign remainder   = p[N-1:0];
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb_seq_divider_16by8: directed and randomized checks of the sequential divider
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int DBZ_LAT = 0;
`else
    localparam int DBZ_LAT = 16;
`endif

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // present operands for one accept edge; returns #1 after that edge
    task automatic start(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // number of further rising edges until out_valid, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 0);
        check({tag, "_ir_back"}, 32'(in_ready), 1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [15:0] eq, input logic [7:0] er,
                          input logic edz);
        int lat;
        start(a, b);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_ir_low"}, 32'(in_ready), 0);
        release_out(tag);
    endtask

    initial begin
        int lat;
        logic [15:0] a;
        logic [7:0]  b;
        logic [31:0] prod;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ir", 32'(in_ready), 1);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);

        run_op("basic", 16'd200, 8'd7, 16, 16'd28, 8'd4, 1'b0);
        run_op("max255", 16'd65535, 8'd255, 16, 16'd257, 8'd0, 1'b0);
        run_op("max1", 16'd65535, 8'd1, 16, 16'd65535, 8'd0, 1'b0);
        run_op("small", 16'd5, 8'd9, 16, 16'd0, 8'd5, 1'b0);
        run_op("dbz", 16'd100, 8'd0, DBZ_LAT, 16'd65535, 8'd100, 1'b1);
        run_op("after_dbz", 16'd144, 8'd12, 16, 16'd12, 8'd0, 1'b0);

        // backpressure: result held, stray operands ignored
        start(16'd1000, 8'd13);
        wait_done(lat);
        check("bp_lat", 32'(lat), 16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            dividend = 16'd7;
            divisor  = 8'd7;
            check("bp_ov", 32'(out_valid), 1);
            check("bp_q", 32'(quotient), 76);
            check("bp_r", 32'(remainder), 12);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("bp");
        run_op("post_bp", 16'd50, 8'd6, 16, 16'd8, 8'd2, 1'b0);

        // reset in the middle of an operation
        start(16'd40000, 8'd3);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_ov", 32'(out_valid), 0);
        check("mid_rst_ir", 32'(in_ready), 1);
        check("mid_rst_q", 32'(quotient), 0);
        check("mid_rst_r", 32'(remainder), 0);
        check("mid_rst_dbz", 32'(div_by_zero), 0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_quiet", 32'(out_valid), 0);
        run_op("post_rst", 16'd9, 8'd4, 16, 16'd2, 8'd1, 1'b0);

        // random invariant checks
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(255, 1));
            start(a, b);
            wait_done(lat);
            prod = 32'(quotient) * 32'(b) + 32'(remainder);
            check("rnd_lat", 32'(lat), 16);
            check("rnd_sum", prod, 32'(a));
            check("rnd_rlt", 32'(remainder < b), 1);
            check("rnd_q", 32'(quotient), 32'(a / 16'(b)));
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
